// File: rtl/seq_adder_pkg.sv
// Shared types and elaboration checks for the multi-cycle chunked adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The operand must split into whole chunks.
    function automatic bit split_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full adders; also exposes the carry into the MSB.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             msb_cin
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout    = c[CHUNK];
    assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// Sequential adder: WIDTH-bit add done CHUNK bits per cycle with valid/ready handshakes.
// Optional subtract mode (extra "sub" port) is enabled by defining SEQ_ADDER_SUB_EN.
module seq_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    if (!split_ok(WIDTH, CHUNK)) begin : g_bad_split
        $error("seq_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state, state_n;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_r, b_r, s_r;
    logic             carry, cout_r, ovf_r;
    logic             op_sub;
    logic [CHUNK-1:0] sum_chunk;
    logic             c_out, c_msb;

`ifdef SEQ_ADDER_SUB_EN
    assign op_sub = sub;
`else
    assign op_sub = 1'b0;
`endif

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a       (a_r[k*CHUNK +: CHUNK]),
        .b       (b_r[k*CHUNK +: CHUNK]),
        .cin     (carry),
        .s       (sum_chunk),
        .cout    (c_out),
        .msb_cin (c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid)     state_n = BUSY;
            BUSY:    if (k == K_LAST)  state_n = DONE;
            DONE:    if (out_ready)    state_n = IDLE;
            default:                   state_n = IDLE;
        endcase
    end

    // Subtraction is folded in at accept time: store ~b and force the carry to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            k      <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r    <= a;
                    b_r    <= op_sub ? ~b : b;
                    carry  <= op_sub ? 1'b1 : cin;
                    k      <= '0;
                    s_r    <= '0;
                    cout_r <= 1'b0;
                    ovf_r  <= 1'b0;
                end
                BUSY: begin
                    s_r[k*CHUNK +: CHUNK] <= sum_chunk;
                    carry <= c_out;
                    k     <= k + KW'(1);
                    if (k == K_LAST) begin
                        cout_r <= c_out;
                        ovf_r  <= c_out ^ c_msb;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign s         = s_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: vector table, multi-cycle corner cases, random and streaming traffic.
module tb_seq_adder;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, s;
    logic         cin, cout, ovf;
`ifdef SEQ_ADDER_SUB_EN
    logic         sub;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SEQ_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_s;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic; overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
        logic [W-1:0] yy;
        logic [W:0]   sum;
        logic         v;
        yy  = sb ? ~y : y;
        sum = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        v   = (x[W-1] == yy[W-1]) && (sum[W-1] != x[W-1]);
        return {v, sum};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction. lat = edges from accept (accept edge counted as 1) until out_valid.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic xs, input int hold,
                         output logic [W-1:0] rs, output logic rc, output logic rv, output int lat);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin step(); t++; end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = xa; b = xb; cin = xc;
`ifdef SEQ_ADDER_SUB_EN
        sub = xs;
`else
        if (xs) $display("note: subtract requested but not built");
`endif
        step();
        lat = 1;
        // Garbage on inputs outside IDLE must not disturb the operation.
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SEQ_ADDER_SUB_EN
        sub = 1'($urandom);
`endif
        while (!out_valid && lat < 50) begin step(); lat++; end
        in_valid = 1'b0;
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
        rs = s; rc = cout; rv = ovf;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_s", 32'(s), 32'(rs));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_ready", 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[6];
    logic [W+1:0] m;
    logic [W-1:0] rs;
    logic         rc, rv;
    int           lat;

    initial begin
        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, (i == 2) ? 10 : 0, rs, rc, rv, lat);
            chk($sformatf("vec%0d_s", i), 32'(rs), 32'(vecs[i].exp_s));
            chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(vecs[i].exp_cout));
            chk($sformatf("vec%0d_ovf", i), 32'(rv), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(N + 1));
        end

        // Reset in the 2nd BUSY cycle discards the operation.
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_cout", 32'(cout), 32'd0);
        step();
        rst = 1'b0;
        do_op(16'd3, 16'd4, 1'b0, 1'b0, 0, rs, rc, rv, lat);
        chk("after_rst_s", 32'(rs), 32'd7);
        chk("after_rst_latency", 32'(lat), 32'(N + 1));

`ifdef SEQ_ADDER_SUB_EN
        do_op(16'd5, 16'd7, 1'b1, 1'b1, 0, rs, rc, rv, lat);
        chk("sub_s", 32'(rs), 32'hFFFE);
        chk("sub_cout", 32'(rc), 32'd0);
        chk("sub_ovf", 32'(rv), 32'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] xa, xb;
            logic xc, xs;
            xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
`ifdef SEQ_ADDER_SUB_EN
            xs = 1'($urandom);
`else
            xs = 1'b0;
`endif
            m = model(xa, xb, xc, xs);
            do_op(xa, xb, xc, xs, int'($urandom_range(0, 2)), rs, rc, rv, lat);
            chk("rand_s", 32'(rs), 32'(m[W-1:0]));
            chk("rand_cout", 32'(rc), 32'(m[W]));
            chk("rand_ovf", 32'(rv), 32'(m[W+1]));
        end

        // Streaming: one result every N+2 cycles, in order, none lost or duplicated.
        begin
            logic [W+1:0] q[$];
            logic [W+1:0] e;
            int results, last_cyc;
            results = 0; last_cyc = -1;
            in_valid = 1'b1; out_ready = 1'b1;
`ifdef SEQ_ADDER_SUB_EN
            sub = 1'b0;
`endif
            for (int cyc = 0; cyc < 80; cyc++) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                #1;
                if (in_ready) q.push_back(model(a, b, cin, 1'b0));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("stream_extra_result", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("stream_s", 32'(s), 32'(e[W-1:0]));
                        chk("stream_cout", 32'(cout), 32'(e[W]));
                        chk("stream_ovf", 32'(ovf), 32'(e[W+1]));
                    end
                    if (last_cyc >= 0) chk("stream_period", 32'(cyc - last_cyc), 32'(N + 2));
                    last_cyc = cyc;
                    results++;
                end
                step();
            end
            in_valid = 1'b0;
            chk("stream_count", 32'(results >= 80 / (N + 2) - 1), 32'd1);
            chk("stream_pending", 32'(q.size() <= 1), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
